// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8 data bits LSB first, 1 stop bit; even parity with UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Parity_Err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       rx_byte;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit;
`else
    assign o_Rx_Parity_Err = 1'b0;
`endif

    // Synchroniser resets to the idle level so reset release never fakes an edge.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            rx_byte        <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= '0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit      <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
`endif
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Rx_Parity_Err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    idx         <= '0;
                    o_Rx_Active <= 1'b0;
                    if (rx_prev && !rx_s) begin
                        state       <= START;
                        o_Rx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state       <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt          <= '0;
                        rx_byte[idx] <= rx_s;
                        idx          <= idx + 1'b1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        parity_bit <= rx_s;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= CLEANUP;
                        // A bad stop bit outranks a parity mismatch.
                        if (!rx_s) begin
                            o_Rx_Frame_Err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (^{rx_byte, parity_bit}) begin
                            o_Rx_Parity_Err <= 1'b1;
`endif
                        end else begin
                            o_Rx_Byte <= rx_byte;
                            o_Rx_DV   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    if (rx_s) begin
                        state       <= IDLE;
                        o_Rx_Active <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end
endmodule
